// File: rtl/layer_sequencer_pkg.sv
// layer_sequencer_pkg: stage, mode and main-state codes shared by the training-flow sequencer
package layer_sequencer_pkg;
  localparam int MODE_LEN = 2;
  localparam logic [MODE_LEN-1:0] TRAIN = 2'd0, FORWARD = 2'd1, GEN_SIMI = 2'd2, GEN_NEW = 2'd3;
  localparam logic [2:0] M_IDLE = 3'd0, M_FF = 3'd1, M_FB = 3'd2, M_LB = 3'd3, M_UPDATE = 3'd4,
                         M_FIN = 3'd5, M_ERR = 3'd6;
  localparam logic [3:0] F_IDLE = 4'd0, F_RECV = 4'd1, F_EMB = 4'd2, F_MIX = 4'd3, F_TANH = 4'd4,
                         F_DENS = 4'd5, F_COMP = 4'd6, F_SEND = 4'd7, F_FIN = 4'd8;
  localparam logic [2:0] B_IDLE = 3'd0, B_SMAX = 3'd1, B_DENS = 3'd2, B_TANH = 3'd3, B_MIX = 3'd4,
                         B_EMB = 3'd5, B_FIN = 3'd6;
endpackage

// File: rtl/layer_sequencer_stage_watchdog.sv
// stage_watchdog: counts cycles spent in one state and fires at limit-1; limit 0 disables
module stage_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         fire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || clear || !enable) ? '0 : cnt + 1'b1;
  assign fire = enable && limit != '0 && cnt == limit - 1'b1;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: main/forward/backward training-flow FSMs with batching, GEN_NEW entry and watchdog
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int N_MIX = 3,
  parameter int BATCH_W = 8,
  parameter int N_PARAM = 3,
  parameter int TIMEOUT_W = 16,
  localparam int LW = N_MIX > 1 ? $clog2(N_MIX) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 next,
  input  logic                 abort,
  input  logic [MODE_LEN-1:0]  mode,
  input  logic [BATCH_W-1:0]   batch_len,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [6:0]           f_valid,
  input  logic [4:0]           b_valid,
  input  logic [N_PARAM-1:0]   valid_zero_grad,
  input  logic [N_PARAM-1:0]   valid_update,
  output logic [2:0]           main_state,
  output logic [3:0]           f_stage,
  output logic [LW-1:0]        f_layer,
  output logic [2:0]           b_stage,
  output logic [LW-1:0]        b_layer,
  output logic                 load_backward,
  output logic                 zero_grad,
  output logic                 update,
  output logic [2:0]           finish,
  output logic [BATCH_W-1:0]   batch_cnt,
  output logic                 timeout_err
);
  localparam logic [LW-1:0] LAST = LW'(N_MIX - 1);
  logic [2:0] m_nx, b_nx;
  logic [3:0] f_nx;
  logic [LW-1:0] fl_nx, bl_nx;
  logic [7:0] fv, bv;
  logic cnt_inc, lb_raw, fire, go, f_hit, b_hit, f_fin, b_fin;
  // Stage code indexes its own done bit; idle/fin codes land on constant zeros
  assign fv = {f_valid, 1'b0};
  assign bv = {2'b00, b_valid, 1'b0};
  assign f_hit = !f_stage[3] && fv[f_stage[2:0]];
  assign b_hit = bv[b_stage];
  assign f_fin = f_stage == F_FIN;
  assign b_fin = b_stage == B_FIN;
  always_comb begin
    m_nx = main_state;
    cnt_inc = 1'b0;
    case (main_state)
      M_IDLE: m_nx = run ? M_FF : M_IDLE;
      M_FF: if (f_fin && &valid_zero_grad)
        m_nx = mode != TRAIN ? M_FIN : batch_len[BATCH_W-1:1] == '0 ? M_LB : M_FB;
      M_FB: if (f_fin && b_fin) begin
        cnt_inc = 1'b1;
        m_nx = batch_cnt + 1'b1 == batch_len - 1'b1 ? M_LB : M_FB;
      end
      M_LB: m_nx = b_fin ? M_UPDATE : M_LB;
      M_UPDATE: m_nx = &valid_update ? M_FIN : M_UPDATE;
      M_FIN: m_nx = next ? M_IDLE : M_FIN;
      default: m_nx = main_state;
    endcase
  end
  // FB self-loop counts as a transition so both pipelines restart for the next sample
  assign lb_raw = m_nx != main_state || cnt_inc;
  assign go = !fire && main_state != M_ERR;
  assign load_backward = !abort && (lb_raw || fire);
  always_comb begin
    f_nx = f_stage;
    fl_nx = f_layer;
    if (f_stage == F_IDLE && (main_state == M_FF || main_state == M_FB)) begin
      f_nx = mode == GEN_NEW ? F_MIX : F_RECV;
      fl_nx = mode == GEN_NEW ? LAST : f_layer;
    end else if (f_fin && lb_raw) f_nx = F_IDLE;
    else if (f_hit) begin
      f_nx = f_stage == F_TANH && f_layer != LAST ? F_MIX : f_stage + 4'd1;
      fl_nx = f_stage == F_EMB ? '0 : f_stage == F_TANH && f_layer != LAST ? f_layer + 1'b1 : f_layer;
    end
  end
  always_comb begin
    b_nx = b_stage;
    bl_nx = b_layer;
    if (b_stage == B_IDLE && (main_state == M_FB || main_state == M_LB)) b_nx = B_SMAX;
    else if (b_fin && lb_raw) b_nx = B_IDLE;
    else if (b_hit) begin
      b_nx = b_stage == B_MIX && b_layer != '0 ? B_TANH : b_stage + 3'd1;
      bl_nx = b_stage == B_DENS ? LAST : b_stage == B_MIX && b_layer != '0 ? b_layer - 1'b1 : b_layer;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      main_state <= M_IDLE;
      f_stage <= F_IDLE;
      b_stage <= B_IDLE;
      f_layer <= '0;
      b_layer <= '0;
      batch_cnt <= '0;
    end else begin
      main_state <= fire ? M_ERR : m_nx;
      if (go) begin
        f_stage <= f_nx;
        f_layer <= fl_nx;
        b_stage <= b_nx;
        b_layer <= bl_nx;
        batch_cnt <= main_state == M_FIN && next ? '0 : batch_cnt + BATCH_W'(cnt_inc);
      end
    end
  end
  stage_watchdog #(.W(TIMEOUT_W)) u_wd (
    .clk(clk),
    .rst(rst || abort),
    .clear(m_nx != main_state || f_nx != f_stage || b_nx != b_stage),
    .enable(main_state == M_FF || main_state == M_FB || main_state == M_LB || main_state == M_UPDATE),
    .limit(timeout),
    .fire(fire)
  );
  assign zero_grad = main_state == M_FF;
  assign update = main_state == M_UPDATE;
  assign finish = {b_fin, f_fin, main_state == M_FIN};
  assign timeout_err = main_state == M_ERR;
endmodule
